x_stack_mpu: RTL and testbench

//  Parametrised access-control monitor. Successor to the fixed three-rule secure-ROM monitor.

---
 rtl/x_stack_mpu.sv | 149 ++++++++++++++
 tb/tb_x_stack_mpu.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/x_stack_mpu.sv
// Access-control monitor: checks pc/data accesses against NREG data regions and a trusted-code window,
// holding reset after a violation. Optional macro ENTRY_CHECK_EN adds the trusted-window entry-point check.
module x_stack_mpu #(
  parameter int unsigned                ADDR_W        = 16,
  parameter int unsigned                NREG          = 4,
  parameter logic [NREG*ADDR_W-1:0]     REG_BASE      = 64'hFEFE_9000_8000_A000,
  parameter logic [NREG*ADDR_W-1:0]     REG_SIZE      = 64'h001F_001F_001F_1000,
  parameter logic [NREG-1:0]            RD_PROT       = 4'b1001,
  parameter logic [NREG-1:0]            WR_PROT       = 4'b1101,
  parameter logic [NREG-1:0]            TW_OK         = 4'b0111,
  parameter logic [ADDR_W-1:0]          SMEM_BASE     = 16'hE000,
  parameter logic [ADDR_W-1:0]          SMEM_SIZE     = 16'h1000,
  parameter logic [ADDR_W-1:0]          RESET_HANDLER = 16'hFFFE,
  parameter int unsigned                HOLD_CYCLES   = 4,
  parameter int unsigned                CNT_W         = 8,
  localparam int unsigned               REG_W         = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic              r_en,
  input  logic              w_en,
  output logic              reset,
  output logic [3:0]        viol_type,
  output logic [REG_W-1:0]  viol_region,
  output logic [CNT_W-1:0]  viol_count
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned WIDE_W = ADDR_W + 1;

  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] KILL = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              reset_q, reset_d;
  logic [3:0]        type_q, type_d;
  logic [REG_W-1:0]  region_q, region_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [WIDE_W-1:0] addr_w, pc_w, smem_end, base_w, end_w;
  logic [NREG-1:0]   hit, ur_mask, uw_mask, contrib;
  logic              trusted, ur, uw, tw, entry_viol, viol;
  logic [3:0]        cause;
  logic [REG_W-1:0]  region_c;

  // Region hits and trusted-window decode; one extra bit keeps BASE+SIZE from wrapping
  always_comb begin
    hit      = '0;
    base_w   = '0;
    end_w    = '0;
    addr_w   = {1'b0, data_addr};
    pc_w     = {1'b0, pc};
    smem_end = {1'b0, SMEM_BASE} + {1'b0, SMEM_SIZE};
    for (int i = 0; i < int'(NREG); i++) begin
      base_w = {1'b0, REG_BASE[i*ADDR_W +: ADDR_W]};
      end_w  = base_w + {1'b0, REG_SIZE[i*ADDR_W +: ADDR_W]};
      hit[i] = (addr_w >= base_w) && (addr_w < end_w);
    end
    trusted = (pc_w >= {1'b0, SMEM_BASE}) && ((pc_w + WIDE_W'(1)) < smem_end);
  end

`ifdef ENTRY_CHECK_EN
  logic prev_trusted_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_trusted_q <= 1'b0;
    else     prev_trusted_q <= trusted;
  end

  assign entry_viol = trusted & ~prev_trusted_q & (pc != SMEM_BASE);
`else
  assign entry_viol = 1'b0;
`endif

  // Violation causes and the lowest region that contributed to them
  always_comb begin
    ur_mask  = hit & RD_PROT & {NREG{r_en & ~trusted}};
    uw_mask  = hit & WR_PROT & {NREG{w_en & ~trusted}};
    ur       = |ur_mask;
    uw       = |uw_mask;
    tw       = trusted & w_en & ~(|(hit & TW_OK));
    cause    = {entry_viol, tw, uw, ur};
    viol     = |cause;
    contrib  = ur_mask | uw_mask | (tw ? hit : '0);
    region_c = '0;
    for (int i = int'(NREG) - 1; i >= 0; i--) begin
      if (contrib[i]) region_c = REG_W'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    reset_d  = reset_q;
    type_d   = type_q;
    region_d = region_q;
    count_d  = count_q;
    hold_d   = hold_q;
    case (state_q)
      RUN: begin
        if (viol) begin
          state_d  = KILL;
          reset_d  = 1'b1;
          type_d   = cause;
          region_d = region_c;
          hold_d   = HOLD_W'(HOLD_CYCLES - 1);
          count_d  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
        end
      end
      KILL: begin
        if (hold_q != '0) hold_d = hold_q - HOLD_W'(1);
        if ((hold_q == '0) && (pc == RESET_HANDLER) && !viol) begin
          state_d = RUN;
          reset_d = 1'b0;
        end
      end
      default: begin
        state_d = RUN;
        reset_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      reset_q  <= 1'b0;
      type_q   <= '0;
      region_q <= '0;
      count_q  <= '0;
      hold_q   <= '0;
    end else begin
      state_q  <= state_d;
      reset_q  <= reset_d;
      type_q   <= type_d;
      region_q <= region_d;
      count_q  <= count_d;
      hold_q   <= hold_d;
    end
  end

  assign reset       = reset_q;
  assign viol_type   = type_q;
  assign viol_region = region_q;
  assign viol_count  = count_q;

endmodule

// File: tb/tb_x_stack_mpu.sv
// Directed bench for x_stack_mpu with hand-computed expectations (default parameters).
module tb_x_stack_mpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc, data_addr;
  logic        r_en, w_en;
  logic        reset;
  logic [3:0]  viol_type;
  logic [1:0]  viol_region;
  logic [7:0]  viol_count;

  int tests  = 0;
  int errors = 0;
  int exp_cnt = 0;
  int n;

  x_stack_mpu dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .data_addr   (data_addr),
    .r_en        (r_en),
    .w_en        (w_en),
    .reset       (reset),
    .viol_type   (viol_type),
    .viol_region (viol_region),
    .viol_count  (viol_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] p, input logic [15:0] a, input logic r, input logic w);
    pc = p; data_addr = a; r_en = r; w_en = w;
  endtask

  // Park pc on the reset handler until reset drops; returns the number of edges taken
  task automatic exit_kill(output int cycles);
    drive(16'hFFFE, 16'h0000, 1'b0, 1'b0);
    cycles = 0;
    do begin
      step();
      cycles++;
    end while (reset && cycles < 20);
    if (reset) check("exit_timeout", 32'(reset), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    drive(16'h4400, 16'h0000, 1'b0, 1'b0);
    #12;
    check("rst_reset", 32'(reset), 0);
    check("rst_type", 32'(viol_type), 0);
    check("rst_region", 32'(viol_region), 0);
    check("rst_count", 32'(viol_count), 0);
    rst = 1'b0;
    step();
    check("idle_no_viol", 32'(reset), 0);

    // 1: untrusted read of protected region 0
    drive(16'h4400, 16'hA010, 1'b1, 1'b0);
    step(); exp_cnt++;
    check("t1_reset", 32'(reset), 1);
    check("t1_type", 32'(viol_type), 4'b0001);
    check("t1_region", 32'(viol_region), 0);
    check("t1_count", 32'(viol_count), 32'(exp_cnt));
    drive(16'h4400, 16'h0000, 1'b0, 1'b0);
    repeat (6) step();
    check("t1_hold_wrong_pc", 32'(reset), 1);
    exit_kill(n);
    check("t1_exit_cycles", 32'(n), 1);

    // 2: trusted write outside TW_OK regions; handler reached on 2nd KILL cycle
    drive(16'hE000, 16'h0000, 1'b0, 1'b0);
    step();
    drive(16'hE100, 16'h0200, 1'b0, 1'b1);
    step(); exp_cnt++;
    check("t2_type", 32'(viol_type), 4'b0100);
    check("t2_region", 32'(viol_region), 0);
    check("t2_kill1", 32'(reset), 1);
    drive(16'h4400, 16'h0000, 1'b0, 1'b0);
    step();
    check("t2_kill2", 32'(reset), 1);
    drive(16'hFFFE, 16'h0000, 1'b0, 1'b0);
    step();
    check("t2_kill3", 32'(reset), 1);
    step();
    check("t2_kill4", 32'(reset), 1);
    step();
    check("t2_exit", 32'(reset), 0);

    // 3: region 2 is write-protected but not read-protected
    drive(16'h4400, 16'h9005, 1'b1, 1'b0);
    step();
    check("t3_read_ok", 32'(reset), 0);
    drive(16'h4400, 16'h9005, 1'b0, 1'b1);
    step(); exp_cnt++;
    check("t3_type", 32'(viol_type), 4'b0010);
    check("t3_region", 32'(viol_region), 2);
    check("t3_count", 32'(viol_count), 32'(exp_cnt));
    exit_kill(n);
    check("t3_exit_cycles", 32'(n), 4);

    // Boundaries: region 0 top edge, just past it, trusted write into TW_OK region, trusted window end
    drive(16'h4400, 16'hB000, 1'b1, 1'b0);
    step();
    check("b_past_region0", 32'(reset), 0);
    drive(16'hEFFF, 16'h0200, 1'b0, 1'b1);
    step();
    check("b_pc_efff_untrusted", 32'(reset), 0);
    drive(16'hE000, 16'h0000, 1'b0, 1'b0);
    step();
    drive(16'hE100, 16'hA000, 1'b0, 1'b1);
    step();
    check("b_trusted_tw_ok", 32'(reset), 0);
    drive(16'hEFFE, 16'h0200, 1'b0, 1'b1);
    step(); exp_cnt++;
    check("b_pc_effe_trusted", 32'(viol_type), 4'b0100);
    exit_kill(n);
    drive(16'h4400, 16'hAFFF, 1'b1, 1'b0);
    step(); exp_cnt++;
    check("b_region0_top", 32'(viol_type), 4'b0001);
    exit_kill(n);

    // 4: trusted read of region 3 is fine, untrusted read is not
    drive(16'hE000, 16'h0000, 1'b0, 1'b0);
    step();
    drive(16'hE100, 16'hFF00, 1'b1, 1'b0);
    step();
    check("t4_trusted_read", 32'(reset), 0);
    drive(16'h4400, 16'hFF00, 1'b1, 1'b0);
    step(); exp_cnt++;
    check("t4_type", 32'(viol_type), 4'b0001);
    check("t4_region", 32'(viol_region), 3);
    check("t4_count", 32'(viol_count), 32'(exp_cnt));
    exit_kill(n);

    // Saturation of the violation counter
    for (int i = 0; i < 300; i++) begin
      drive(16'h4400, 16'hA000, 1'b1, 1'b0);
      step();
      exit_kill(n);
    end
    check("t4_saturate", 32'(viol_count), 255);

    // 5: violation while in KILL keeps KILL and leaves the recorded cause alone
    drive(16'h4400, 16'h9000, 1'b0, 1'b1);
    step();
    check("t5_enter", 32'(viol_type), 4'b0010);
    drive(16'hFFFE, 16'hA000, 1'b0, 1'b1);
    repeat (6) step();
    check("t5_stay_kill", 32'(reset), 1);
    check("t5_type_held", 32'(viol_type), 4'b0010);
    check("t5_region_held", 32'(viol_region), 2);
    check("t5_count_held", 32'(viol_count), 255);
    #2 rst = 1'b1;
    #1;
    check("t5_async_reset", 32'(reset), 0);
    check("t5_async_type", 32'(viol_type), 0);
    check("t5_async_count", 32'(viol_count), 0);
    drive(16'h4400, 16'h0000, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    step();
    check("t5_run_after_rst", 32'(reset), 0);

`ifdef ENTRY_CHECK_EN
    // 6: entry into the trusted window must land on its base
    drive(16'h4400, 16'h0000, 1'b0, 1'b0);
    step();
    drive(16'hE010, 16'h0000, 1'b0, 1'b0);
    step();
    check("t6_bad_entry", 32'(viol_type), 4'b1000);
    check("t6_bad_region", 32'(viol_region), 0);
    exit_kill(n);
    drive(16'h4400, 16'h0000, 1'b0, 1'b0);
    step();
    drive(16'hE000, 16'h0000, 1'b0, 1'b0);
    step();
    check("t6_good_entry", 32'(reset), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
